// File: rtl/sgd_weight_updater.sv
// SGD consumer of the gradient bank: w <= sat(w - ((lr*g) >>> FRACTIONAL_BITS)), then clears g.
// Optional gradient clipping to +/-CLIP_LIMIT when `GRAD_CLIP_EN is defined.
module sgd_weight_updater #(
  parameter int unsigned FIXED_BITS      = 8,
  parameter int unsigned FRACTIONAL_BITS = 8,
  parameter int unsigned NUM_WEIGHTS     = 16,
  parameter int unsigned ADDR_W          = 4,
  parameter logic [FIXED_BITS+FRACTIONAL_BITS-1:0] CLIP_LIMIT =
    (FIXED_BITS+FRACTIONAL_BITS)'(16'h0400)
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             start,
  input  logic signed [FIXED_BITS+FRACTIONAL_BITS-1:0]     learning_rate,
  output logic                                             busy,
  output logic                                             done,
  output logic        [ADDR_W-1:0]                         idx,
  output logic                                             grad_rd_en,
  input  logic signed [FIXED_BITS+FRACTIONAL_BITS-1:0]     grad_rdata,
  output logic                                             grad_clear_en,
  output logic                                             w_rd_en,
  input  logic signed [FIXED_BITS+FRACTIONAL_BITS-1:0]     w_rdata,
  output logic                                             w_wr_en,
  output logic signed [FIXED_BITS+FRACTIONAL_BITS-1:0]     w_wdata
);

  localparam int unsigned W   = FIXED_BITS + FRACTIONAL_BITS;
  localparam int unsigned P_W = 2 * W;
  localparam int unsigned D_W = W + FIXED_BITS + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHTS - 1);

  localparam logic signed [D_W-1:0] SAT_MAX = D_W'(2**(W-1) - 1);
  localparam logic signed [D_W-1:0] SAT_MIN = D_W'(-(2**(W-1)));

  localparam logic signed [W-1:0] CLIP_POS = CLIP_LIMIT;
  localparam logic signed [W-1:0] CLIP_NEG = -CLIP_POS;

`ifdef GRAD_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  logic [2:0]              state, state_nxt;
  logic [ADDR_W-1:0]       idx_nxt;
  logic signed [W-1:0]     lr_q, lr_nxt;
  logic signed [W-1:0]     w_wdata_nxt;
  logic                    busy_nxt, done_nxt;
  logic                    grad_rd_en_nxt, w_rd_en_nxt;
  logic                    grad_clear_en_nxt, w_wr_en_nxt;

  logic signed [W-1:0]     g_use;
  logic signed [P_W-1:0]   prod;
  logic signed [P_W-1:0]   shifted;
  logic signed [D_W-1:0]   diff;
  logic signed [W-1:0]     upd;

  // Update datapath: optional clip, full-precision product, floor shift, saturating subtract
  always_comb begin
    g_use = grad_rdata;
    if (CLIP_ON) begin
      if (grad_rdata > CLIP_POS) begin
        g_use = CLIP_POS;
      end else if (grad_rdata < CLIP_NEG) begin
        g_use = CLIP_NEG;
      end
    end
    prod    = P_W'(lr_q) * P_W'(g_use);
    shifted = prod >>> FRACTIONAL_BITS;
    diff    = D_W'(w_rdata) - D_W'(shifted);
    if (diff > SAT_MAX) begin
      upd = {1'b0, {(W-1){1'b1}}};
    end else if (diff < SAT_MIN) begin
      upd = {1'b1, {(W-1){1'b0}}};
    end else begin
      upd = diff[W-1:0];
    end
  end

  // Next-state and next-output logic; every output is registered from these
  always_comb begin
    state_nxt         = state;
    idx_nxt           = idx;
    lr_nxt            = lr_q;
    w_wdata_nxt       = w_wdata;
    done_nxt          = 1'b0;
    grad_rd_en_nxt    = 1'b0;
    w_rd_en_nxt       = 1'b0;
    grad_clear_en_nxt = 1'b0;
    w_wr_en_nxt       = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          lr_nxt         = learning_rate;
          idx_nxt        = '0;
          state_nxt      = S_READ;
          grad_rd_en_nxt = 1'b1;
          w_rd_en_nxt    = 1'b1;
        end
      end
      S_READ: begin
        state_nxt = S_CALC;
      end
      S_CALC: begin
        w_wdata_nxt       = upd;
        w_wr_en_nxt       = 1'b1;
        grad_clear_en_nxt = 1'b1;
        state_nxt         = S_WRITE;
      end
      S_WRITE: begin
        if (idx == LAST_IDX) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else begin
          idx_nxt        = idx + ADDR_W'(1);
          state_nxt      = S_READ;
          grad_rd_en_nxt = 1'b1;
          w_rd_en_nxt    = 1'b1;
        end
      end
      S_DONE: begin
        idx_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        idx_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      lr_q          <= '0;
      w_wdata       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      grad_rd_en    <= 1'b0;
      w_rd_en       <= 1'b0;
      grad_clear_en <= 1'b0;
      w_wr_en       <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      lr_q          <= lr_nxt;
      w_wdata       <= w_wdata_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      grad_rd_en    <= grad_rd_en_nxt;
      w_rd_en       <= w_rd_en_nxt;
      grad_clear_en <= grad_clear_en_nxt;
      w_wr_en       <= w_wr_en_nxt;
    end
  end

endmodule

// File: tb/tb_sgd_weight_updater.sv
// Bench for sgd_weight_updater: 1-cycle-latency gradient/weight memories, vector table,
// random passes against an integer reference model, timing and mid-pass reset checks.
module tb_sgd_weight_updater;

  localparam int N = 16;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic signed [15:0] learning_rate;
  logic               busy, done;
  logic [3:0]         idx;
  logic               grad_rd_en, grad_clear_en, w_rd_en, w_wr_en;
  logic signed [15:0] grad_rdata, w_rdata, w_wdata;

  logic [15:0] gmem [N];
  logic [15:0] wmem [N];
  logic [15:0] pre_g [N];
  logic [15:0] pre_w [N];
  logic        load;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] lr;
    logic [15:0] g;
    logic [15:0] w;
    logic [15:0] exp;
  } vec_t;

  sgd_weight_updater dut (
    .clk(clk), .rst_n(rst_n), .start(start), .learning_rate(learning_rate),
    .busy(busy), .done(done), .idx(idx),
    .grad_rd_en(grad_rd_en), .grad_rdata(grad_rdata), .grad_clear_en(grad_clear_en),
    .w_rd_en(w_rd_en), .w_rdata(w_rdata), .w_wr_en(w_wr_en), .w_wdata(w_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models with one cycle of read latency
  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < N; k++) begin
        gmem[k] <= pre_g[k];
        wmem[k] <= pre_w[k];
      end
    end else begin
      if (grad_rd_en)    grad_rdata <= gmem[idx];
      if (w_rd_en)       w_rdata    <= wmem[idx];
      if (grad_clear_en) gmem[idx]  <= 16'h0000;
      if (w_wr_en)       wmem[idx]  <= w_wdata;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] lr, input logic [15:0] g,
                                        input logic [15:0] w);
    longint li, gi, wi, p, s, d;
    li = longint'($signed(lr));
    gi = longint'($signed(g));
    wi = longint'($signed(w));
`ifdef GRAD_CLIP_EN
    if (gi > 1024)  gi = 1024;
    if (gi < -1024) gi = -1024;
`endif
    p = li * gi;
    if (p >= 0) s = p / 256;
    else        s = -((-p + 255) / 256);
    d = wi - s;
    if (d > 32767)  d = 32767;
    if (d < -32768) d = -32768;
    return 16'(d);
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_idx"}, idx, 0);
    chk({tag, "_strobes"}, {grad_rd_en, grad_clear_en, w_rd_en, w_wr_en}, 0);
    chk({tag, "_wdata"}, {48'b0, w_wdata}, 0);
  endtask

  // One update pass; rst_cyc>0 asserts reset in that cycle, restart_cyc>0 re-pulses start
  task automatic do_pass(input logic [15:0] lr, input int rst_cyc, input int restart_cyc);
    logic [15:0] exp_w [N];
    int  nwr;
    bit  fin;
    bit  written;
    for (int k = 0; k < N; k++) exp_w[k] = model(lr, pre_g[k], pre_w[k]);
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
    learning_rate = lr;
    start = 1'b1;
    nwr = 0;
    fin = 1'b0;
    for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        learning_rate = 16'($urandom);
      end
      if (cyc == restart_cyc) begin
        start = 1'b1;
        learning_rate = ~lr;
      end
      if (restart_cyc != 0 && cyc == restart_cyc + 1) start = 1'b0;
      chk("busy_in_pass", busy, 1);
      chk("rd_wr_excl", w_rd_en & w_wr_en, 0);
      if (grad_rd_en || w_rd_en) begin
        chk("rd_pair", {grad_rd_en, w_rd_en}, 2'b11);
        chk("rd_cycle", cyc, 3 * nwr + 1);
        chk("rd_idx", idx, nwr);
      end
      if (w_wr_en) begin
        chk("wr_cycle", cyc, 3 * nwr + 3);
        chk("wr_idx", idx, nwr);
        chk("clr_with_wr", grad_clear_en, 1);
        nwr++;
      end else begin
        chk("clr_without_wr", grad_clear_en, 0);
      end
      if (cyc == rst_cyc) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midreset");
        rst_n = 1'b1;
        fin = 1'b1;
      end else if (done) begin
        chk("done_cycle", cyc, 3 * N + 1);
        chk("n_writes", nwr, N);
        chk("done_idx", idx, N - 1);
        fin = 1'b1;
      end
    end
    chk("pass_finished", fin, 1);
    if (rst_cyc == 0) begin
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_idx", idx, 0);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_late_strobe", {grad_rd_en, grad_clear_en, w_rd_en, w_wr_en}, 0);
    end
    for (int k = 0; k < N; k++) begin
      written = (rst_cyc == 0) || (3 * k + 3 < rst_cyc);
      chk($sformatf("w_mem[%0d]", k), wmem[k], written ? exp_w[k] : pre_w[k]);
      chk($sformatf("g_mem[%0d]", k), gmem[k], written ? 16'h0000 : pre_g[k]);
    end
  endtask

  task automatic fill_random(input bit small_vals);
    for (int k = 0; k < N; k++) begin
      pre_g[k] = small_vals ? 16'($signed(12'($urandom))) : 16'($urandom);
      pre_w[k] = 16'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    vecs[0] = '{16'h0080, 16'h0200, 16'h0300, 16'h0200};
    vecs[1] = '{16'h0100, 16'h7FFF, 16'h8001, 16'h8000};
    vecs[2] = '{16'h0100, 16'h8000, 16'h7F00, 16'h7FFF};
    vecs[3] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0001};
`ifdef GRAD_CLIP_EN
    vecs[4] = '{16'h0100, 16'h1000, 16'h0000, 16'hFC00};
`else
    vecs[4] = '{16'h0100, 16'h1000, 16'h0000, 16'hF000};
`endif

    rst_n = 1'b0;
    start = 1'b1;
    learning_rate = 16'h0100;
    load = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", busy, 0);

    // Table vectors placed at the first and last slots of a pass
    for (int i = 0; i < 5; i++) begin
      fill_random(1'b1);
      pre_g[0] = vecs[i].g;
      pre_w[0] = vecs[i].w;
      pre_g[N-1] = vecs[i].g;
      pre_w[N-1] = vecs[i].w;
      do_pass(vecs[i].lr, 0, (i == 0) ? 10 : 0);
      chk($sformatf("vec%0d_first", i), wmem[0], vecs[i].exp);
      chk($sformatf("vec%0d_last", i), wmem[N-1], vecs[i].exp);
    end

    // Randomised passes checked against the reference model
    for (int r = 0; r < 4; r++) begin
      fill_random(r[0]);
      do_pass((r == 3) ? 16'($urandom) : 16'($urandom_range(0, 16'h0200)), 0, 0);
    end

    // Reset during weight 5 CALC, then a recovery pass
    fill_random(1'b1);
    do_pass(16'h0040, 17, 0);
    fill_random(1'b0);
    do_pass(16'($urandom_range(0, 16'h0400)), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
